core_ctrl: RTL and testbench
============================

# core_ctrl

Pipeline control unit for the xrv32i core. It sits beside the pc_reg / if_id / id_ex / ex chain and sequences it:
- redirects the PC on taken jumps and flushes the wrong-path instructions;
- stalls the front end on load-use hazards, multi-cycle EX operations and instruction-fetch wait states;
- detects fetch timeouts;
- counts stall cycles for performance monitoring.

## Interface
Parameters:
- ADDR_W, 32, PC / jump address width
- REG_ADDR_W, 5, register index width
- BUS_TIMEOUT, 16, maximum consecutive BUS_WAIT cycles before fetch error
- CNT_W, 16, stall cycle counter width

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- jump_req_in  in  1  taken jump/branch from core_ex
- jump_addr_in  in  ADDR_W  jump target from core_ex
- ex_hold_req_in  in  1  multi-cycle EX operation in progress
- bus_hold_req_in  in  1  instruction ROM not ready this cycle
- id_rs1_in, id_rs2_in  in  REG_ADDR_W each  source registers of instruction in ID
- id_rs1_used_in, id_rs2_used_in  in  1 each  source actually read
- ex_rd_in  in  REG_ADDR_W  destination of instruction in EX
- ex_is_load_in  in  1  EX instruction is a load
- ex_reg_we_in  in  1  EX instruction writes a register
- jump_flag_out  out  1  to core_pc_reg jump_flag_in
- jump_addr_out  out  ADDR_W  to core_pc_reg jump_addr_in
- hold_pc_out  out  1  to core_pc_reg hold_flag_in
- hold_if_id_out  out  1  freeze core_if_id
- hold_id_ex_out  out  1  freeze core_id_ex
- flush_if_id_out  out  1  load NOP into core_if_id
- flush_id_ex_out  out  1  load NOP into core_id_ex
- bus_err_out  out  1  sticky fetch timeout flag
- stall_cnt_out  out  CNT_W  saturating count of cycles with hold_pc_out=1
- state_out  out  2  FSM state (RUN=0, FLUSH=1, LOAD_STALL=2, BUS_WAIT=3)

## Operation
- **Output style:** control outputs are Mealy: combinational from the current state and inputs. While rst=1 they are forced to 0.
- **Priority:** jump > ex_hold > load-use > bus_hold. A higher-priority cause fully determines the outputs for that cycle.
- **Load-use hazard:** ex_is_load_in & ex_reg_we_in & ex_rd_in≠0 & ((id_rs1_used_in & id_rs1_in==ex_rd_in) | (id_rs2_used_in & id_rs2_in==ex_rd_in)).

RUN:
- **Jump:** jump_flag_out=1, jump_addr_out=jump_addr_in, flush_if_id_out=1, flush_id_ex_out=1. Next state FLUSH.
- **ex_hold:** hold_pc_out, hold_if_id_out and hold_id_ex_out all =1. State stays RUN.
- **Load-use:** hold_pc_out=1, hold_if_id_out=1, flush_id_ex_out=1 (inserts a bubble). Next state LOAD_STALL.
- **bus_hold** (only when bus_err_out=0): hold_pc_out=1, flush_if_id_out=1. Counter cleared to 1. Next state BUS_WAIT.

FLUSH (lasts 1 cycle):
- jump_req_in is ignored.
- ex_hold is honoured.
- Hazard check is suppressed.
- Next state RUN, or BUS_WAIT if bus_hold applies, with the same outputs as the RUN bus_hold entry.

LOAD_STALL (lasts 1 cycle):
- Jump is handled exactly as in RUN.
- Hazard check is suppressed.
- Otherwise behaves as RUN, including the bus_hold entry.

BUS_WAIT:
- **Jump:** handled as in RUN, counter cleared, next state FLUSH.
- **ex_hold:** all three holds asserted. The counter still increments.
- **bus_hold_req_in=1:** hold_pc_out=1, flush_if_id_out=1, counter increments.
  - If the counter equals BUS_TIMEOUT: bus_err_out←1, counter cleared, next state RUN.
- **bus_hold_req_in=0:** next state RUN, counter cleared.

Fetch error and counters:
- Once bus_err_out=1, bus_hold_req_in is masked until reset.
- stall_cnt_out increments on every cycle with hold_pc_out=1 and saturates at all-ones.
- The BUS_WAIT counter has width $clog2(BUS_TIMEOUT+1).

## Timing
- **Reset:** all outputs 0, state RUN, BUS_WAIT counter 0, bus_err_out 0, stall_cnt_out 0. Reset takes effect immediately, asynchronously.
- **Reset mid-operation:** an in-progress BUS_WAIT or FLUSH is abandoned. The first cycle after rst deasserts is RUN.
- **Jump:** redirect and flush are asserted in the same cycle as jump_req_in. The PC equals the target on the next edge. Exactly 1 extra FLUSH cycle follows.
- **Load-use:** costs exactly 1 bubble cycle. The same ID instruction is re-checked only after LOAD_STALL.
- **Fetch timeout:** bus_err_out rises on the edge ending the BUS_TIMEOUT-th consecutive BUS_WAIT cycle.
- **Simultaneous events:**
  - jump with ex_hold: jump wins, no holds asserted.
  - load-use with bus_hold: load-use wins; bus_hold is re-evaluated in LOAD_STALL.

## Test plan
- **Reset:** assert rst mid-BUS_WAIT → all outputs 0 immediately, state_out=0, stall_cnt_out=0.
- **Jump:** jump_req_in=1, jump_addr_in=0x0000_0100 in RUN → same cycle jump_flag_out=1, jump_addr_out=0x100, both flushes=1. Next cycle state_out=1; a jump_req_in pulse there is ignored. Following cycle state_out=0.
- **Load-use:** ex_is_load_in=1, ex_reg_we_in=1, ex_rd_in=5, id_rs2_in=5, id_rs2_used_in=1 → 1 cycle with hold_pc_out, hold_if_id_out, flush_id_ex_out=1. Then LOAD_STALL, then RUN. Repeat with ex_rd_in=0 → no stall.
- **Fetch wait and timeout:**
  - bus_hold_req_in=1 for 3 cycles → 3 cycles with hold_pc_out=1, then RUN; stall_cnt_out=3.
  - bus_hold_req_in held 20 cycles with BUS_TIMEOUT=16 → bus_err_out=1 after cycle 16; holds drop afterwards and stay dropped.
- **Priority:** jump_req_in and ex_hold_req_in together → jump_flag_out=1, all holds 0. ex_hold during BUS_WAIT → all three holds=1.
- **Saturation:** CNT_W=4, hold for 20 cycles → stall_cnt_out stops at 15.

Source files
------------

// File: rtl/core_ctrl.sv
// core_ctrl: pipeline sequencer for the xrv32i core.
// Drives PC redirect, stage holds and flushes, fetch-timeout detection
// and a saturating stall-cycle counter. Control outputs are Mealy.
//
// state      | meaning
// -----------+-----------------------------------------------------
// RUN        | normal issue, all hazard sources evaluated
// FLUSH      | one cycle after a redirect, jumps and hazards ignored
// LOAD_STALL | one bubble cycle after a load-use hazard
// BUS_WAIT   | instruction fetch waiting on the ROM, timeout armed
module core_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int BUS_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  jump_req_in,
    input  logic [ADDR_W-1:0]     jump_addr_in,
    input  logic                  ex_hold_req_in,
    input  logic                  bus_hold_req_in,
    input  logic [REG_ADDR_W-1:0] id_rs1_in,
    input  logic [REG_ADDR_W-1:0] id_rs2_in,
    input  logic                  id_rs1_used_in,
    input  logic                  id_rs2_used_in,
    input  logic [REG_ADDR_W-1:0] ex_rd_in,
    input  logic                  ex_is_load_in,
    input  logic                  ex_reg_we_in,
    output logic                  jump_flag_out,
    output logic [ADDR_W-1:0]     jump_addr_out,
    output logic                  hold_pc_out,
    output logic                  hold_if_id_out,
    output logic                  hold_id_ex_out,
    output logic                  flush_if_id_out,
    output logic                  flush_id_ex_out,
    output logic                  bus_err_out,
    output logic [CNT_W-1:0]      stall_cnt_out,
    output logic [1:0]            state_out
);

    localparam logic [1:0] S_RUN        = 2'd0;
    localparam logic [1:0] S_FLUSH      = 2'd1;
    localparam logic [1:0] S_LOAD_STALL = 2'd2;
    localparam logic [1:0] S_BUS_WAIT   = 2'd3;

    localparam int BW = $clog2(BUS_TIMEOUT + 1);
    localparam logic [BW-1:0] BCNT_ONE = BW'(1);
    localparam logic [BW-1:0] BCNT_TO  = BW'(BUS_TIMEOUT);

    logic [1:0]        state_q, state_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_q;

    logic              jump_c, hold_pc_c, hold_if_id_c, hold_id_ex_c;
    logic              flush_if_id_c, flush_id_ex_c;
    logic [ADDR_W-1:0] jaddr_c;
    logic              hazard, bus_hold_eff;

    // Load-use detection against the instruction currently in EX
    always_comb begin
        hazard = ex_is_load_in && ex_reg_we_in && (ex_rd_in != '0) &&
                 ((id_rs1_used_in && (id_rs1_in == ex_rd_in)) ||
                  (id_rs2_used_in && (id_rs2_in == ex_rd_in)));
        bus_hold_eff = bus_hold_req_in && !err_q;
    end

    // Next-state and Mealy control decode, priority jump > ex_hold > load-use > bus_hold
    always_comb begin
        state_d       = state_q;
        bcnt_d        = bcnt_q;
        err_d         = err_q;
        jump_c        = 1'b0;
        jaddr_c       = '0;
        hold_pc_c     = 1'b0;
        hold_if_id_c  = 1'b0;
        hold_id_ex_c  = 1'b0;
        flush_if_id_c = 1'b0;
        flush_id_ex_c = 1'b0;
        case (state_q)
            S_BUS_WAIT: begin
                if (jump_req_in) begin
                    jump_c        = 1'b1;
                    jaddr_c       = jump_addr_in;
                    flush_if_id_c = 1'b1;
                    flush_id_ex_c = 1'b1;
                    bcnt_d        = '0;
                    state_d       = S_FLUSH;
                end else if (ex_hold_req_in) begin
                    hold_pc_c    = 1'b1;
                    hold_if_id_c = 1'b1;
                    hold_id_ex_c = 1'b1;
                    if (bcnt_q != '1) bcnt_d = bcnt_q + BCNT_ONE;
                end else if (bus_hold_eff) begin
                    hold_pc_c     = 1'b1;
                    flush_if_id_c = 1'b1;
                    if (bcnt_q == BCNT_TO) begin
                        err_d   = 1'b1;
                        bcnt_d  = '0;
                        state_d = S_RUN;
                    end else begin
                        bcnt_d = bcnt_q + BCNT_ONE;
                    end
                end else begin
                    bcnt_d  = '0;
                    state_d = S_RUN;
                end
            end
            default: begin
                // RUN, FLUSH and LOAD_STALL share decode; FLUSH ignores jumps,
                // only RUN evaluates the hazard.
                if (jump_req_in && (state_q != S_FLUSH)) begin
                    jump_c        = 1'b1;
                    jaddr_c       = jump_addr_in;
                    flush_if_id_c = 1'b1;
                    flush_id_ex_c = 1'b1;
                    state_d       = S_FLUSH;
                end else if (ex_hold_req_in) begin
                    hold_pc_c    = 1'b1;
                    hold_if_id_c = 1'b1;
                    hold_id_ex_c = 1'b1;
                    state_d      = S_RUN;
                end else if (hazard && (state_q == S_RUN)) begin
                    hold_pc_c     = 1'b1;
                    hold_if_id_c  = 1'b1;
                    flush_id_ex_c = 1'b1;
                    state_d       = S_LOAD_STALL;
                end else if (bus_hold_eff) begin
                    hold_pc_c     = 1'b1;
                    flush_if_id_c = 1'b1;
                    bcnt_d        = BCNT_ONE;
                    state_d       = S_BUS_WAIT;
                end else begin
                    state_d = S_RUN;
                end
            end
        endcase
    end

    // State, timeout counter and sticky error register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            bcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            err_q   <= err_d;
        end
    end

    // Saturating count of cycles in which the PC is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (hold_pc_c && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    // Control outputs are forced low for as long as reset is asserted
    always_comb begin
        jump_flag_out   = jump_c        && !rst;
        jump_addr_out   = rst ? '0 : jaddr_c;
        hold_pc_out     = hold_pc_c     && !rst;
        hold_if_id_out  = hold_if_id_c  && !rst;
        hold_id_ex_out  = hold_id_ex_c  && !rst;
        flush_if_id_out = flush_if_id_c && !rst;
        flush_id_ex_out = flush_id_ex_c && !rst;
    end

    assign bus_err_out   = err_q;
    assign stall_cnt_out = stall_q;
    assign state_out     = state_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl; a second instance with CNT_W=4 shares the
// stimulus to observe stall counter saturation.
module tb_core_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_req_in;
    logic [31:0] jump_addr_in;
    logic        ex_hold_req_in, bus_hold_req_in;
    logic [4:0]  id_rs1_in, id_rs2_in, ex_rd_in;
    logic        id_rs1_used_in, id_rs2_used_in;
    logic        ex_is_load_in, ex_reg_we_in;

    logic        jump_flag_out, hold_pc_out, hold_if_id_out, hold_id_ex_out;
    logic        flush_if_id_out, flush_id_ex_out, bus_err_out;
    logic [31:0] jump_addr_out;
    logic [15:0] stall_cnt_out;
    logic [1:0]  state_out;

    logic        s_jump_flag, s_hold_pc, s_hold_if_id, s_hold_id_ex;
    logic        s_flush_if_id, s_flush_id_ex, s_bus_err;
    logic [31:0] s_jump_addr;
    logic [3:0]  s_stall_cnt;
    logic [1:0]  s_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    core_ctrl u_dut (
        .clk(clk), .rst(rst),
        .jump_req_in(jump_req_in), .jump_addr_in(jump_addr_in),
        .ex_hold_req_in(ex_hold_req_in), .bus_hold_req_in(bus_hold_req_in),
        .id_rs1_in(id_rs1_in), .id_rs2_in(id_rs2_in),
        .id_rs1_used_in(id_rs1_used_in), .id_rs2_used_in(id_rs2_used_in),
        .ex_rd_in(ex_rd_in), .ex_is_load_in(ex_is_load_in), .ex_reg_we_in(ex_reg_we_in),
        .jump_flag_out(jump_flag_out), .jump_addr_out(jump_addr_out),
        .hold_pc_out(hold_pc_out), .hold_if_id_out(hold_if_id_out),
        .hold_id_ex_out(hold_id_ex_out), .flush_if_id_out(flush_if_id_out),
        .flush_id_ex_out(flush_id_ex_out), .bus_err_out(bus_err_out),
        .stall_cnt_out(stall_cnt_out), .state_out(state_out)
    );

    core_ctrl #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .jump_req_in(jump_req_in), .jump_addr_in(jump_addr_in),
        .ex_hold_req_in(ex_hold_req_in), .bus_hold_req_in(bus_hold_req_in),
        .id_rs1_in(id_rs1_in), .id_rs2_in(id_rs2_in),
        .id_rs1_used_in(id_rs1_used_in), .id_rs2_used_in(id_rs2_used_in),
        .ex_rd_in(ex_rd_in), .ex_is_load_in(ex_is_load_in), .ex_reg_we_in(ex_reg_we_in),
        .jump_flag_out(s_jump_flag), .jump_addr_out(s_jump_addr),
        .hold_pc_out(s_hold_pc), .hold_if_id_out(s_hold_if_id),
        .hold_id_ex_out(s_hold_id_ex), .flush_if_id_out(s_flush_if_id),
        .flush_id_ex_out(s_flush_id_ex), .bus_err_out(s_bus_err),
        .stall_cnt_out(s_stall_cnt), .state_out(s_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        jump_req_in = 0; jump_addr_in = '0; ex_hold_req_in = 0; bus_hold_req_in = 0;
        id_rs1_in = '0; id_rs2_in = '0; id_rs1_used_in = 0; id_rs2_used_in = 0;
        ex_rd_in = '0; ex_is_load_in = 0; ex_reg_we_in = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clr_in();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_holds(input string tag, input logic pc, input logic ifid, input logic idex);
        check({tag, "_hold_pc"}, hold_pc_out, pc);
        check({tag, "_hold_if_id"}, hold_if_id_out, ifid);
        check({tag, "_hold_id_ex"}, hold_id_ex_out, idex);
    endtask

    initial begin
        rst = 1'b1;
        clr_in();
        repeat (2) @(negedge clk);
        #1;
        check("rst_state", state_out, 0);
        check("rst_stall", stall_cnt_out, 0);
        check("rst_err", bus_err_out, 0);
        check("rst_jump", jump_flag_out, 0);
        @(negedge clk);
        rst = 1'b0;

        // Jump in RUN, ignored pulse in FLUSH, back to RUN
        @(negedge clk);
        jump_req_in = 1; jump_addr_in = 32'h0000_0100;
        #1;
        check("jmp_flag", jump_flag_out, 1);
        check("jmp_addr", jump_addr_out, 32'h100);
        check("jmp_fl_ifid", flush_if_id_out, 1);
        check("jmp_fl_idex", flush_id_ex_out, 1);
        @(negedge clk);
        jump_addr_in = 32'h0000_0200;
        #1;
        check("flush_state", state_out, 1);
        check("flush_ign_jmp", jump_flag_out, 0);
        check("flush_ign_fl", flush_if_id_out, 0);
        @(negedge clk);
        clr_in();
        #1;
        check("post_flush_state", state_out, 0);

        // Jump together with ex_hold: jump wins; ex_hold honoured in FLUSH
        @(negedge clk);
        jump_req_in = 1; ex_hold_req_in = 1; jump_addr_in = 32'h0000_0040;
        #1;
        check("pri_jmp_flag", jump_flag_out, 1);
        check_holds("pri_jmp", 0, 0, 0);
        @(negedge clk);
        jump_req_in = 0;
        #1;
        check("pri_flush_state", state_out, 1);
        check_holds("flush_exh", 1, 1, 1);
        @(negedge clk);
        clr_in();
        #1;
        check("pri_ret_state", state_out, 0);
        check("stall_after_flush_exh", stall_cnt_out, 1);

        // Load-use together with bus_hold: load-use wins, bus_hold taken in LOAD_STALL
        @(negedge clk);
        ex_is_load_in = 1; ex_reg_we_in = 1; ex_rd_in = 5; id_rs2_in = 5; id_rs2_used_in = 1;
        bus_hold_req_in = 1;
        #1;
        check_holds("lu", 1, 1, 0);
        check("lu_fl_idex", flush_id_ex_out, 1);
        check("lu_fl_ifid", flush_if_id_out, 0);
        @(negedge clk);
        #1;
        check("ls_state", state_out, 2);
        check("ls_bus_hold_pc", hold_pc_out, 1);
        check("ls_bus_fl_ifid", flush_if_id_out, 1);
        check("ls_no_bubble", flush_id_ex_out, 0);
        @(negedge clk);
        bus_hold_req_in = 0;
        #1;
        check("ls_bw_state", state_out, 3);
        check("bw_release_hold", hold_pc_out, 0);
        @(negedge clk);
        #1;
        check("bw_ret_state", state_out, 0);
        check("stall_after_lu", stall_cnt_out, 3);

        // Plain load-use then RUN; then ex_rd=0 must not stall
        do_reset();
        ex_is_load_in = 1; ex_reg_we_in = 1; ex_rd_in = 5; id_rs2_in = 5; id_rs2_used_in = 1;
        #1;
        check("lu2_hold", hold_pc_out, 1);
        @(negedge clk);
        clr_in();
        #1;
        check("lu2_ls_state", state_out, 2);
        check("lu2_ls_hold", hold_pc_out, 0);
        @(negedge clk);
        #1;
        check("lu2_run_state", state_out, 0);
        ex_is_load_in = 1; ex_reg_we_in = 1; ex_rd_in = 0; id_rs2_in = 0; id_rs2_used_in = 1;
        #1;
        check("x0_no_hold", hold_pc_out, 0);
        check("x0_no_bubble", flush_id_ex_out, 0);
        @(negedge clk);
        clr_in();
        #1;
        check("x0_state", state_out, 0);

        // Asynchronous reset in the middle of BUS_WAIT
        @(negedge clk);
        bus_hold_req_in = 1;
        @(negedge clk);
        #1;
        check("pre_rst_state", state_out, 3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_hold", hold_pc_out, 0);
        check("arst_flush", flush_if_id_out, 0);
        check("arst_state", state_out, 0);
        check("arst_stall", stall_cnt_out, 0);
        @(negedge clk);
        clr_in();
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_state", state_out, 0);

        // Three-cycle fetch wait
        do_reset();
        bus_hold_req_in = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bw3_hold_%0d", i), hold_pc_out, 1);
            check($sformatf("bw3_fl_%0d", i), flush_if_id_out, 1);
            @(negedge clk);
        end
        bus_hold_req_in = 0;
        #1;
        check("bw3_drop", hold_pc_out, 0);
        @(negedge clk);
        #1;
        check("bw3_state", state_out, 0);
        check("bw3_stall", stall_cnt_out, 3);

        // ex_hold during BUS_WAIT asserts all three holds
        @(negedge clk);
        bus_hold_req_in = 1;
        @(negedge clk);
        ex_hold_req_in = 1;
        #1;
        check("bw_exh_state", state_out, 3);
        check_holds("bw_exh", 1, 1, 1);
        @(negedge clk);
        clr_in();
        @(negedge clk);
        #1;
        check("bw_exh_ret", state_out, 0);

        // Fetch timeout: entry cycle + 16 BUS_WAIT cycles hold, then masked
        do_reset();
        bus_hold_req_in = 1;
        for (int i = 0; i < 20; i++) begin
            #1;
            check($sformatf("to_hold_%0d", i), hold_pc_out, (i <= 16) ? 1'b1 : 1'b0);
            check($sformatf("to_err_%0d", i), bus_err_out, (i >= 17) ? 1'b1 : 1'b0);
            @(negedge clk);
        end
        #1;
        check("to_state", state_out, 0);
        check("to_stall", stall_cnt_out, 17);
        check("to_sat_stall", s_stall_cnt, 15);
        check("to_sat_err", s_bus_err, 1);
        clr_in();

        // Stall counter saturation with ex_hold for 20 cycles
        do_reset();
        ex_hold_req_in = 1;
        repeat (20) @(negedge clk);
        ex_hold_req_in = 0;
        #1;
        check("sat_wide", stall_cnt_out, 20);
        check("sat_narrow", s_stall_cnt, 15);
        check("sat_err_cleared", bus_err_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
